// File: rtl/mult_share_ctrl_if.sv
// Request/response bundle for mult_share_ctrl.
//   req0_*/req1_* : two requester channels (valid/ready plus a/x operands)
//   rsp_*         : response channel (valid/ready plus requester id and product)
// master = client side (drives requests, consumes responses); slave = controller.
interface mult_share_ctrl_if #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 4
);
  logic           req0_valid;
  logic           req0_ready;
  logic [M-1:0]   req0_a;
  logic [N-1:0]   req0_x;
  logic           req1_valid;
  logic           req1_ready;
  logic [M-1:0]   req1_a;
  logic [N-1:0]   req1_x;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [M+N-1:0] rsp_product;

  modport master (
    output req0_valid, req0_a, req0_x,
    output req1_valid, req1_a, req1_x,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req0_valid, req0_a, req0_x,
    input  req1_valid, req1_a, req1_x,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Shares one combinational M x N multiplier between two requesters.
// Round-robin arbitration in IDLE, operands held on mul_a/mul_x for SETTLE
// cycles, product captured and returned with the requester id.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : requester channels and response channel
//   mul_a, mul_x : registered operands to the shared multiplier
//   mul_product  : multiplier result (combinational from mul_a/mul_x)
//   busy         : high whenever the controller is not in IDLE
// SETTLE must be in 1..15.
module mult_share_ctrl #(
  parameter int unsigned M      = 4,
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  mult_share_ctrl_if.slave bus,
  output logic [M-1:0]   mul_a,
  output logic [N-1:0]   mul_x,
  input  logic [M+N-1:0] mul_product,
  output logic           busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned PW = M + N;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q;
  logic            ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [PW-1:0]   rsp_product_q;
  logic            gnt0;
  logic            gnt1;

  // Round-robin grant; ptr names the requester favoured on a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
      gnt1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
    end
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;

  // Controller state, operand and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      cnt_q         <= '0;
      mul_a         <= '0;
      mul_x         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= '0;
      busy          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0) begin
            mul_a    <= bus.req0_a;
            mul_x    <= bus.req0_x;
            rsp_id_q <= 1'b0;
            ptr_q    <= 1'b1;
            cnt_q    <= CW'(SETTLE - 1);
            busy     <= 1'b1;
            state_q  <= WAIT;
          end else if (gnt1) begin
            mul_a    <= bus.req1_a;
            mul_x    <= bus.req1_x;
            rsp_id_q <= 1'b1;
            ptr_q    <= 1'b0;
            cnt_q    <= CW'(SETTLE - 1);
            busy     <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          // Operands have been stable for SETTLE cycles once cnt reaches 0.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_product_q <= mul_product;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a behavioural multiplier,
// a round-robin reference model and randomized operand traffic.
module tb_mult_share_ctrl;

  localparam int SETTLE0 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mul_a, mul_x, mul_a1, mul_x1;
  logic [7:0] mul_product, mul_product1;
  logic       busy, busy1;

  int tests = 0;
  int fails = 0;

  // Reference state: favoured requester and pending operand pairs.
  bit         m_ptr = 1'b0;
  bit         p0_v = 1'b0, p1_v = 1'b0;
  logic [3:0] p0_a = '0, p0_x = '0, p1_a = '0, p1_x = '0;
  int         obs_id;
  logic [7:0] obs_prod;

  mult_share_ctrl_if #(.M(4), .N(4)) bus ();
  mult_share_ctrl_if #(.M(4), .N(4)) bus1 ();

  assign mul_product  = {4'b0, mul_a}  * {4'b0, mul_x};
  assign mul_product1 = {4'b0, mul_a1} * {4'b0, mul_x1};

  mult_share_ctrl #(.M(4), .N(4), .SETTLE(SETTLE0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_a(mul_a), .mul_x(mul_x), .mul_product(mul_product), .busy(busy)
  );

  mult_share_ctrl #(.M(4), .N(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .mul_a(mul_a1), .mul_x(mul_x1), .mul_product(mul_product1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs;
    bus.req0_valid = p0_v;
    bus.req0_a     = p0_a;
    bus.req0_x     = p0_x;
    bus.req1_valid = p1_v;
    bus.req1_a     = p1_a;
    bus.req1_x     = p1_x;
  endtask

  // Presents the pending requests, follows one operation to completion
  // with `stall` back-pressure cycles, and records the observed response.
  task automatic serve_one(input int stall);
    bit exp_r0, exp_r1;
    int wid, lat;
    logic [3:0] ea, ex;
    logic [7:0] eprod;
    drive_reqs();
    #1;
    exp_r0 = p0_v && (!p1_v || m_ptr == 1'b0);
    exp_r1 = p1_v && (!p0_v || m_ptr == 1'b1);
    tests++;
    if (bus.req0_ready !== exp_r0 || bus.req1_ready !== exp_r1) begin
      fails++;
      $display("FAIL arb_ready: got r0=%b r1=%b, expected r0=%b r1=%b",
               bus.req0_ready, bus.req1_ready, exp_r0, exp_r1);
    end
    wid   = exp_r0 ? 0 : 1;
    ea    = (wid == 0) ? p0_a : p1_a;
    ex    = (wid == 0) ? p0_x : p1_x;
    eprod = {4'b0, ea} * {4'b0, ex};
    m_ptr = (wid == 0);
    tick;
    if (wid == 0) p0_v = 1'b0; else p1_v = 1'b0;
    drive_reqs();
    #1;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      tests++;
      if (busy !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        fails++;
        $display("FAIL wait_state: busy=%b r0=%b r1=%b, expected busy=1 r0=0 r1=0",
                 busy, bus.req0_ready, bus.req1_ready);
      end
      tick;
      lat++;
    end
    tests++;
    if (lat != SETTLE0 + 1) begin
      fails++;
      $display("FAIL latency: got %0d cycles, expected %0d", lat, SETTLE0 + 1);
      if (lat >= 40) return;
    end
    obs_id   = int'(bus.rsp_id);
    obs_prod = bus.rsp_product;
    tests++;
    if (bus.rsp_product !== eprod || bus.rsp_id !== wid[0] ||
        mul_a !== ea || mul_x !== ex || busy !== 1'b1) begin
      fails++;
      $display("FAIL response: got prod=%0d id=%b a=%0d x=%0d busy=%b, expected prod=%0d id=%0d a=%0d x=%0d busy=1",
               bus.rsp_product, bus.rsp_id, mul_a, mul_x, busy, eprod, wid, ea, ex);
    end
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = 1'b0;
      tick;
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== eprod || bus.rsp_id !== wid[0] ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          mul_a !== ea || mul_x !== ex) begin
        fails++;
        $display("FAIL hold: got v=%b prod=%0d id=%b r0=%b r1=%b a=%0d x=%0d, expected v=1 prod=%0d id=%0d r0=0 r1=0 a=%0d x=%0d",
                 bus.rsp_valid, bus.rsp_product, bus.rsp_id, bus.req0_ready,
                 bus.req1_ready, mul_a, mul_x, eprod, wid, ea, ex);
      end
    end
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || mul_a !== ea || mul_x !== ex) begin
      fails++;
      $display("FAIL release: got v=%b busy=%b a=%0d x=%0d, expected v=0 busy=0 a=%0d x=%0d",
               bus.rsp_valid, busy, mul_a, mul_x, ea, ex);
    end
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_ptr = 1'b0;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    p0_v = 1'b1; p1_v = 1'b1;
    drive_reqs();
    tick;
    tick;
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got r0=%b r1=%b, expected 0 0", bus.req0_ready, bus.req1_ready);
    end
    tests++;
    if (mul_a !== 4'd0 || mul_x !== 4'd0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 ||
        bus.rsp_product !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: got a=%0d x=%0d v=%b id=%b prod=%0d busy=%b, expected all 0",
               mul_a, mul_x, bus.rsp_valid, bus.rsp_id, bus.rsp_product, busy);
    end
    p0_v = 1'b0; p1_v = 1'b0;
    drive_reqs();
    rst   = 1'b0;
    m_ptr = 1'b0;
    tick;
  endtask

  task automatic test_single;
    p0_v = 1'b1; p0_a = 4'd3; p0_x = 4'd5;
    serve_one(0);
    tests++;
    if (obs_prod !== 8'd15 || obs_id != 0) begin
      fails++;
      $display("FAIL single: got prod=%0d id=%0d, expected prod=15 id=0", obs_prod, obs_id);
    end
  endtask

  task automatic test_simultaneous;
    pulse_reset();
    p0_v = 1'b1; p0_a = 4'd7;  p0_x = 4'd9;
    p1_v = 1'b1; p1_a = 4'd15; p1_x = 4'd15;
    serve_one(0);
    tests++;
    if (obs_prod !== 8'd63 || obs_id != 0) begin
      fails++;
      $display("FAIL simul_first: got prod=%0d id=%0d, expected prod=63 id=0", obs_prod, obs_id);
    end
    serve_one(0);
    tests++;
    if (obs_prod !== 8'd225 || obs_id != 1) begin
      fails++;
      $display("FAIL simul_second: got prod=%0d id=%0d, expected prod=225 id=1", obs_prod, obs_id);
    end
  endtask

  task automatic test_fairness;
    for (int i = 0; i < 6; i++) begin
      if (!p0_v) begin p0_v = 1'b1; p0_a = 4'($urandom); p0_x = 4'($urandom); end
      if (!p1_v) begin p1_v = 1'b1; p1_a = 4'($urandom); p1_x = 4'($urandom); end
      serve_one(0);
      tests++;
      if (obs_id != (i % 2)) begin
        fails++;
        $display("FAIL fairness[%0d]: got id=%0d, expected id=%0d", i, obs_id, i % 2);
      end
    end
    p0_v = 1'b0; p1_v = 1'b0;
  endtask

  task automatic test_back_pressure;
    p0_v = 1'b1; p0_a = 4'd12; p0_x = 4'd15;
    p1_v = 1'b1; p1_a = 4'd2;  p1_x = 4'd2;
    serve_one(4);
    tests++;
    if (obs_prod !== 8'hB4) begin
      fails++;
      $display("FAIL back_pressure: got prod=%0h, expected b4", obs_prod);
    end
    serve_one(0);
  endtask

  task automatic test_boundaries;
    logic [3:0] ta [3] = '{4'd0, 4'd15, 4'd15};
    logic [3:0] tx [3] = '{4'd15, 4'd1, 4'd15};
    logic [7:0] tp [3] = '{8'd0, 8'd15, 8'd225};
    for (int i = 0; i < 3; i++) begin
      p1_v = 1'b1; p1_a = ta[i]; p1_x = tx[i];
      serve_one(1);
      tests++;
      if (obs_prod !== tp[i] || obs_id != 1) begin
        fails++;
        $display("FAIL boundary[%0d]: got prod=%0d id=%0d, expected prod=%0d id=1",
                 i, obs_prod, obs_id, tp[i]);
      end
    end
  endtask

  task automatic test_settle1;
    bus1.req1_valid = 1'b1; bus1.req1_a = 4'd6; bus1.req1_x = 4'd7;
    #1;
    tests++;
    if (bus1.req1_ready !== 1'b1 || bus1.req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL s1_accept: got r0=%b r1=%b, expected r0=0 r1=1", bus1.req0_ready, bus1.req1_ready);
    end
    tick;
    bus1.req1_valid = 1'b0;
    tests++;
    if (bus1.rsp_valid !== 1'b0 || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL s1_wait: got v=%b busy=%b, expected v=0 busy=1", bus1.rsp_valid, busy1);
    end
    tick;
    tests++;
    if (bus1.rsp_valid !== 1'b1 || bus1.rsp_product !== 8'd42 || bus1.rsp_id !== 1'b1) begin
      fails++;
      $display("FAIL s1_resp: got v=%b prod=%0d id=%b, expected v=1 prod=42 id=1",
               bus1.rsp_valid, bus1.rsp_product, bus1.rsp_id);
    end
    bus1.rsp_ready = 1'b1;
    tick;
    bus1.rsp_ready = 1'b0;
    tests++;
    if (bus1.rsp_valid !== 1'b0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL s1_release: got v=%b busy=%b, expected v=0 busy=0", bus1.rsp_valid, busy1);
    end
  endtask

  task automatic test_reset_mid;
    p0_v = 1'b1; p0_a = 4'd5; p0_x = 4'd5;
    drive_reqs();
    #1;
    tick;
    p0_v = 1'b0;
    drive_reqs();
    tests++;
    if (busy !== 1'b1 || mul_a !== 4'd5) begin
      fails++;
      $display("FAIL mid_accept: got busy=%b a=%0d, expected busy=1 a=5", busy, mul_a);
    end
    pulse_reset();
    tests++;
    if (mul_a !== 4'd0 || mul_x !== 4'd0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 ||
        bus.rsp_product !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_values: got a=%0d x=%0d v=%b id=%b prod=%0d busy=%b, expected all 0",
               mul_a, mul_x, bus.rsp_valid, bus.rsp_id, bus.rsp_product, busy);
    end
    p0_v = 1'b1; p1_v = 1'b1; p1_a = 4'd9; p1_x = 4'd3;
    drive_reqs();
    #1;
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_ptr: got r0=%b r1=%b, expected r0=1 r1=0", bus.req0_ready, bus.req1_ready);
    end
    p0_v = 1'b0;
    serve_one(0);
    tests++;
    if (obs_id != 1 || obs_prod !== 8'd27) begin
      fails++;
      $display("FAIL mid_next: got id=%0d prod=%0d, expected id=1 prod=27", obs_id, obs_prod);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      if (!p0_v && ($urandom_range(0, 2) != 0)) begin
        p0_v = 1'b1; p0_a = 4'($urandom); p0_x = 4'($urandom);
      end
      if (!p1_v && ($urandom_range(0, 2) != 0)) begin
        p1_v = 1'b1; p1_a = 4'($urandom); p1_x = 4'($urandom);
      end
      if (!p0_v && !p1_v) begin
        p0_v = 1'b1; p0_a = 4'($urandom); p0_x = 4'($urandom);
      end
      serve_one(int'($urandom_range(0, 3)));
    end
    p0_v = 1'b0; p1_v = 1'b0;
    drive_reqs();
  endtask

  initial begin
    bus.rsp_ready   = 1'b0;
    bus1.rsp_ready  = 1'b0;
    bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_x = '0;
    bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_x = '0;
    drive_reqs();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_back_pressure();
    test_boundaries();
    test_settle1();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Controller that shares one combinational array multiplier between two requesters.
- Arbitrates round-robin and drives the multiplier operands from registers.
- Holds the operands stable for a configurable settle time, captures the product and returns it with the requester ID over a valid/ready response channel.
- Sits between client logic and a single multiplier instance (M x N operands, M+N product).

Parameters:
M, 4, width of operand a (multiplicand)
N, 4, width of operand x (multiplier)
SETTLE, 2, cycles the operands are held on mul_a/mul_x before the product is captured; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 operands accepted this cycle when high with req0_valid
req0_a  input  M  requester 0 multiplicand
req0_x  input  N  requester 0 multiplier
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  requester 1 accept
req1_a  input  M  requester 1 multiplicand
req1_x  input  N  requester 1 multiplier
mul_a  output  M  registered operand to multiplier a input
mul_x  output  N  registered operand to multiplier x input
mul_product  input  M+N  multiplier result (combinational from mul_a/mul_x)
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  ID of the requester that issued the response operation
rsp_product  output  M+N  captured unsigned product
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - state=IDLE, ptr=0 (requester 0 favoured), cnt=0.
  - mul_a=0, mul_x=0, rsp_product=0, rsp_id=0, rsp_valid=0, busy=0.
  - req0_ready=0 and req1_ready=0 while rst is high.
- States: IDLE, WAIT, RESP.
- IDLE arbitration (combinational ready):
  - req0_ready = req0_valid & (!req1_valid | ptr==0).
  - req1_ready = req1_valid & (!req0_valid | ptr==1).
  - At most one ready is high. Both readys are 0 outside IDLE.
- Accept (IDLE and valid&ready):
  - Register the winner's a/x into mul_a/mul_x and its ID into rsp_id.
  - Set ptr to the inverse of the granted ID.
  - Set cnt to SETTLE-1 and go to WAIT.
  - With no valid request, remain in IDLE with no state change.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture mul_product into rsp_product and go to RESP.
- RESP:
  - rsp_valid=1. rsp_product and rsp_id are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE with rsp_valid=0 next cycle.
  - A new request may be accepted in the first IDLE cycle after the handshake.
- Latency: accept in cycle t -> WAIT cycles t+1..t+SETTLE -> rsp_valid first high in cycle t+SETTLE+1.
- Throughput: one operation per SETTLE+2 cycles with rsp_ready tied high.
- Operand hold: mul_a/mul_x change only on accept. They stay stable through WAIT, RESP and the following IDLE cycles.
- Width: the product is unsigned, M+N bits, passed through unmodified. No truncation or sign handling.
- Requests are never dropped or reordered. A non-granted valid requester keeps waiting; it must hold valid and operands, and the block does not register pending requests.
- Reset mid-operation (WAIT or RESP): the operation is discarded, no response is issued, and all reset values apply on the next cycle.
- rsp_ready high outside RESP has no effect.

Test Plan:
- Single request: req0 a=3 x=5 accepted cycle 0, SETTLE=2 -> rsp_valid cycle 3, rsp_product=15, rsp_id=0, busy high cycles 1-3.
- Simultaneous requests after reset: req0 7x9, req1 15x15 valid cycle 0 -> req0 served first (63, id 0); req1 accepted in the first IDLE cycle after that response (225, id 1).
- Fairness: both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1; ptr toggles on each accept.
- Back-pressure: hold rsp_ready low 4 cycles in RESP with product 0xB4 -> rsp_valid, rsp_product and rsp_id stable; both readys 0; mul_a/mul_x unchanged.
- Boundaries: 0x15=0, 15x1=15, 15x15=225 (max, bit 7 set). With SETTLE=1, rsp_valid appears 2 cycles after accept.
- Reset in WAIT cycle: assert rst one cycle -> no rsp_valid ever for that op. Next cycle all outputs at reset values and ptr=0. A subsequent req1-only request is accepted immediately.
